// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// PC step and output-buffer depth.
package instr_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC    = 32'd4;
  localparam int          BUF_DEPTH = 2;

endpackage

// File: rtl/instr_fetch_ctrl_buf.sv
// Two-entry {instr, pc} output FIFO for the fetch controller; flush empties it
// and overrides any push or pop in the same cycle.
module fetch_buf
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_instr,
  input  logic [31:0]           push_pc,
  input  logic                  pop,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_instr,
  output logic [31:0]           head_pc,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] instr_reg [BUF_DEPTH];
  logic [31:0]           pc_reg    [BUF_DEPTH];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;
  logic                  do_push;
  logic                  do_pop;

  always_comb begin
    do_pop  = pop && !flush && (count_reg != 2'd0);
    do_push = push && !flush && ((count_reg != 2'(BUF_DEPTH)) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      instr_reg[wr_ptr_reg] <= push_instr;
      pc_reg[wr_ptr_reg]    <= push_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Masking keeps the head at zero whenever the buffer is empty.
  always_comb begin
    head_valid = (count_reg != 2'd0);
    head_instr = head_valid ? instr_reg[rd_ptr_reg] : '0;
    head_pc    = head_valid ? pc_reg[rd_ptr_reg] : '0;
    count      = count_reg;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: issues word reads to a 1-cycle synchronous
// memory, tags them with an epoch, and queues responses in fetch_buf.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [31:0]           instr_pc,
  input  logic                  instr_ready
);

  fetch_state_t          state_reg, state_next;
  logic [31:0]           fetch_pc_reg;
  logic [31:0]           fetch_pc_next;
  logic [ADDR_WIDTH-1:0] imem_addr_reg;
  logic                  inflight_reg;
  logic [31:0]           inflight_pc_reg;
  logic                  inflight_epoch_reg;
  logic                  epoch_reg;
  logic [1:0]            buf_count;
  logic [2:0]            credit;
  logic                  pop;
  logic                  push;
  logic                  issue;

  // Credit counts buffered plus in-flight words, less the one leaving this cycle.
  always_comb begin
    pop           = instr_valid && instr_ready;
    push          = inflight_reg && (inflight_epoch_reg == epoch_reg);
    credit        = {1'b0, buf_count} + {2'b00, inflight_reg} - {2'b00, pop};
    issue         = !reset && enable && !redirect_valid && (credit < 3'(BUF_DEPTH));
    fetch_pc_next = fetch_pc_reg + PC_INC;
  end

  always_comb begin
    state_next = state_reg;
    if (redirect_valid) begin
      state_next = ST_FLUSH;
    end else if (state_reg == ST_FLUSH) begin
      state_next = ST_RUN;
    end else begin
      state_next = issue ? ST_RUN : ST_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= ST_RUN;
      fetch_pc_reg       <= RESET_PC;
      imem_addr_reg      <= RESET_PC[ADDR_WIDTH+1:2];
      inflight_reg       <= 1'b0;
      inflight_pc_reg    <= '0;
      inflight_epoch_reg <= 1'b0;
      epoch_reg          <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (redirect_valid) begin
        fetch_pc_reg  <= redirect_pc & ~32'd3;
        imem_addr_reg <= redirect_pc[ADDR_WIDTH+1:2];
        inflight_reg  <= 1'b0;
        epoch_reg     <= ~epoch_reg;
      end else if (issue) begin
        // imem_addr always mirrors fetch_pc, so the memory sees the word being issued.
        fetch_pc_reg       <= fetch_pc_next;
        imem_addr_reg      <= fetch_pc_next[ADDR_WIDTH+1:2];
        inflight_reg       <= 1'b1;
        inflight_pc_reg    <= fetch_pc_reg;
        inflight_epoch_reg <= epoch_reg;
      end else begin
        inflight_reg <= 1'b0;
      end
    end
  end

  assign imem_addr = imem_addr_reg;

  fetch_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_instr (imem_data),
    .push_pc    (inflight_pc_reg),
    .pop        (pop),
    .head_valid (instr_valid),
    .head_instr (instr),
    .head_pc    (instr_pc),
    .count      (buf_count)
  );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: a memory holding word k = k and a reference that
// predicts the next PC the consumer must see from the reset/redirect history.
module tb_instr_fetch_ctrl;

  localparam int          AW  = 10;
  localparam int          DW  = 32;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [31:0]   instr_pc;
  logic          instr_ready;

  logic [DW-1:0] mem [1 << AW];

  int            errors = 0;
  int            checks = 0;
  logic [31:0]   exp_pc;
  logic          hold_prev;
  logic [DW-1:0] prev_instr;
  logic [31:0]   prev_pc;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  instr_fetch_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC  (RPC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  // Memory word k holds k, so the instruction at a PC is its word index.
  function automatic logic [DW-1:0] exp_word(input logic [31:0] pc);
    return DW'(pc[AW+1:2]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge: drive inputs, check the head against the model,
  // advance the model for what the next rising edge does, then move one cycle.
  task automatic tick(input logic rst, input logic en, input logic rv,
                      input logic [31:0] rpc, input logic rdy);
    reset          = rst;
    enable         = en;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    if (hold_prev) begin
      chk("hold_valid", 64'(instr_valid), 64'(1));
      chk("hold_instr", 64'(instr), 64'(prev_instr));
      chk("hold_pc", 64'(instr_pc), 64'(prev_pc));
    end
    if (instr_valid === 1'b1) begin
      chk("head_pc", 64'(instr_pc), 64'(exp_pc));
      chk("head_instr", 64'(instr), 64'(exp_word(exp_pc)));
      if (rdy && !rst) exp_pc += 32'd4;
    end
    hold_prev  = (instr_valid === 1'b1) && !rdy && !rst && !rv;
    prev_instr = instr;
    prev_pc    = instr_pc;
    if (rst) exp_pc = RPC;
    else if (rv) exp_pc = rpc & ~32'd3;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int            n;
    logic [AW-1:0] a0;
    logic          r_rdy, r_en, r_rv;
    logic [31:0]   r_pc;

    for (int k = 0; k < (1 << AW); k++) mem[k] = DW'(k);
    hold_prev      = 1'b0;
    prev_instr     = '0;
    prev_pc        = '0;
    exp_pc         = RPC;
    reset          = 1'b1;
    enable         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    @(negedge clk);

    repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("rst_valid", 64'(instr_valid), 64'(0));
    chk("rst_instr", 64'(instr), 64'(0));
    chk("rst_pc", 64'(instr_pc), 64'(0));
    chk("rst_addr", 64'(imem_addr), 64'(RPC[AW+1:2]));

    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("first_valid_edge1", 64'(instr_valid), 64'(0));
    chk("addr_after_first_issue", 64'(imem_addr), 64'(RPC[AW+1:2] + 1));
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("first_valid_edge2", 64'(instr_valid), 64'(1));
    chk("first_pc", 64'(instr_pc), 64'(RPC));

    n = 0;
    while (instr_pc !== 32'h20 && n < 40) begin
      chk("stream_throughput", 64'(instr_valid), 64'(1));
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      n++;
    end
    chk("reach_0x20", 64'(instr_pc), 64'(32'h20));

    tick(1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
    chk("redirect_flush", 64'(instr_valid), 64'(0));
    n = 0;
    while (instr_valid !== 1'b1 && n < 10) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      n++;
    end
    chk("redirect_latency", 64'(n), 64'(2));
    chk("redirect_pc_0x100", 64'(instr_pc), 64'(32'h100));
    chk("redirect_instr_64", 64'(instr), 64'(64));

    repeat (5) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    a0 = imem_addr;
    repeat (5) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("stall_addr_frozen", 64'(imem_addr), 64'(a0));
    end
    repeat (10) begin
      chk("resume_throughput", 64'(instr_valid), 64'(1));
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    end

    tick(1'b0, 1'b1, 1'b1, 32'h0FFC, 1'b1);
    chk("wrap_addr_1023", 64'(imem_addr), 64'(1023));
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr_0", 64'(imem_addr), 64'(0));
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_valid", 64'(instr_valid), 64'(1));
    chk("wrap_pc_ffc", 64'(instr_pc), 64'(32'h0FFC));
    chk("wrap_instr_1023", 64'(instr), 64'(1023));
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_pc_1000", 64'(instr_pc), 64'(32'h1000));
    chk("wrap_instr_0", 64'(instr), 64'(0));

    tick(1'b0, 1'b1, 1'b1, 32'h40, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 32'h80, 1'b1);
    n = 0;
    while (instr_valid !== 1'b1 && n < 10) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      n++;
    end
    chk("b2b_valid", 64'(instr_valid), 64'(1));
    chk("b2b_last_wins", 64'(instr_pc), 64'(32'h80));

    repeat (400) begin
      r_rdy = ($urandom_range(0, 3) != 0);
      r_en  = ($urandom_range(0, 4) != 0);
      r_rv  = ($urandom_range(0, 19) == 0);
      r_pc  = $urandom;
      tick(1'b0, r_en, r_rv, r_pc, r_rdy);
    end

    repeat (4) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("pre_reset_buffered", 64'(instr_valid), 64'(1));
    tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("midrst_valid", 64'(instr_valid), 64'(0));
    chk("midrst_addr", 64'(imem_addr), 64'(RPC[AW+1:2]));
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("midrst_edge1", 64'(instr_valid), 64'(0));
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("midrst_edge2", 64'(instr_valid), 64'(1));
    chk("midrst_restart_pc", 64'(instr_pc), 64'(RPC));
    repeat (5) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address width of the instruction memory.
REQ-002 Parameter DATA_WIDTH, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, byte PC loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  high permits new fetch issues; low freezes issuing only.
REQ-007 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-008 redirect_pc  input  32  byte target PC; bits [1:0] ignored.
REQ-009 imem_addr  output  ADDR_WIDTH  word address to instruction memory, registered.
REQ-010 imem_data  input  DATA_WIDTH  instruction memory dataOut; valid the cycle after the edge that sampled imem_addr.
REQ-011 instr_valid  output  1  output buffer head holds a valid instruction.
REQ-012 instr  output  DATA_WIDTH  instruction at buffer head.
REQ-013 instr_pc  output  32  byte PC of instr.
REQ-014 instr_ready  input  1  consumer accepts head when instr_valid && instr_ready at an edge.

Function
REQ-015 Memory read latency SHALL be exactly 1 cycle: request issued at edge N, imem_data captured at edge N+1.
REQ-016 Issue condition: !reset && enable && !redirect_valid && (occupancy + inflight - pop) < 2, where pop = instr_valid && instr_ready.
REQ-017 On issue, fetch_pc SHALL advance by 4; imem_addr = fetch_pc[ADDR_WIDTH+1:2], wrapping 1023 -> 0 with fetch_pc continuing upward.
REQ-018 Output buffer: 2-entry FIFO of {instr, pc}; push on valid in-flight response with matching epoch, pop on handshake; simultaneous push/pop SHALL keep occupancy unchanged.
REQ-019 instr, instr_pc SHALL stay stable while instr_valid && !instr_ready.
REQ-020 Sustained throughput SHALL be 1 instruction/cycle with instr_ready and enable held high.
REQ-021 FSM states: RUN (issuing allowed), HOLD (credit exhausted or enable low), FLUSH (one cycle after redirect); RUN<->HOLD per REQ-016, any -> FLUSH on redirect_valid, FLUSH -> RUN.
REQ-022 Redirect: at the sampling edge, FIFO SHALL be emptied, epoch toggled, fetch_pc := {redirect_pc[31:2],2'b00}; in-flight response of old epoch SHALL be discarded; first issue from new PC on the following edge.
REQ-023 redirect_valid SHALL take priority over push, pop and issue in the same cycle; a pop coinciding with redirect is still a completed handshake.
REQ-024 Back-to-back redirects: the last one wins; no instruction from an intermediate target SHALL appear.
REQ-025 enable low SHALL not drop in-flight responses; they complete into the FIFO.

Reset
REQ-026 While reset is high: fetch_pc = RESET_PC, imem_addr = RESET_PC[ADDR_WIDTH+1:2], instr_valid = 0, instr = 0, instr_pc = 0, occupancy = 0, inflight = 0, epoch = 0, state = RUN.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions at that edge.
REQ-028 First instr_valid SHALL rise at the 2nd rising edge after reset deasserts (enable high, ready don't-care).

Structure
REQ-029 Shared package SHALL hold the FSM state encoding (RUN, FLUSH, HOLD), the PC increment constant 4, and the buffer depth constant 2.
REQ-030 The 2-entry output buffer SHALL be a sub-module named fetch_buf; the FSM, PC, and epoch logic stay in instr_fetch_ctrl.

Verification
REQ-031 Memory preloaded word k = k; reset, enable=1, ready=1 -> instr 0,1,2,... with instr_pc 0,4,8,... one per cycle from 2nd edge after reset.
REQ-032 ready low 5 cycles mid-stream -> occupancy caps at 2, imem_addr frozen, no instruction lost or duplicated on resume.
REQ-033 redirect_pc=0x100 while stream at 0x20 -> next instr_pc seen is 0x100 (instr 64), old in-flight word never output.
REQ-034 redirect_pc=0x0FFC -> instr_pc 0xFFC, 0x1000, imem_addr 1023 then 0.
REQ-035 redirect on two consecutive cycles (0x40, 0x80) -> first output after is 0x80.
REQ-036 reset pulsed with 2 buffered entries -> instr_valid 0 next cycle, restart from RESET_PC.
